// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants and types for the DDS channel scheduler and phase decode
package dds_pkg;

  localparam logic [1:0] Q_FIRST  = 2'b00;
  localparam logic [1:0] Q_SECOND = 2'b01;
  localparam logic [1:0] Q_THIRD  = 2'b10;
  localparam logic [1:0] Q_FOURTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Quarter select occupies the top Q_W bits; the ROM index sits directly below it.
  localparam int Q_W = 2;

  function automatic int quarter_msb(input int acc_w);
    return acc_w - 1;
  endfunction

  function automatic int index_msb(input int acc_w);
    return acc_w - 1 - Q_W;
  endfunction

endpackage

// File: rtl/dds_phase_decode.sv
// rtl/dds_phase_decode.sv - maps a phase accumulator onto a quarter-wave ROM address and sign
module dds_phase_decode
  import dds_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [ADDR_W-1:0] addr,
  output logic              sign
);

  localparam int Q_MSB = quarter_msb(ACC_W);
  localparam int I_MSB = index_msb(ACC_W);
  localparam int LSB_W = ACC_W - Q_W - ADDR_W;

  logic [Q_W-1:0]    q;
  logic [ADDR_W-1:0] idx;

  assign q   = acc[Q_MSB -: Q_W];
  assign idx = acc[I_MSB -: ADDR_W];

  // Fractional phase bits only advance the accumulator; they never reach the ROM.
  if (LSB_W > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^acc[LSB_W-1:0];
  end

  always_comb begin
    addr = idx;
    sign = 1'b0;
    case (q)
      Q_FIRST:  begin addr = idx;  sign = 1'b0; end
      Q_SECOND: begin addr = ~idx; sign = 1'b0; end
      Q_THIRD:  begin addr = idx;  sign = 1'b1; end
      Q_FOURTH: begin addr = ~idx; sign = 1'b1; end
    endcase
  end

endmodule

// File: rtl/dds_channel_scheduler.sv
// rtl/dds_channel_scheduler.sv - time-multiplexes one quarter-wave sine ROM across NCH DDS channels
module dds_channel_scheduler
  import dds_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_tuning,
  input  logic              cfg_en,
  input  logic              cfg_clr,
  input  logic              ovr_clr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W:0]   out_sample,
  output logic              busy,
  output logic              overrun
);

  state_t            state;
  logic [CH_W-1:0]   slot;
  logic [ACC_W-1:0]  acc    [NCH];
  logic [ACC_W-1:0]  tuning [NCH];
  logic [NCH-1:0]    en;

  logic              issuing;
  logic              last_slot;
  logic [ACC_W-1:0]  slot_acc;
  logic              slot_en;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_sign;

  logic              p_valid;
  logic              p_sign;
  logic              p_en;
  logic [CH_W-1:0]   p_ch;
  logic [DATA_W:0]   mag;

  assign issuing   = (state == ISSUE);
  assign last_slot = (slot == CH_W'(NCH - 1));
  assign busy      = (state != IDLE);
  assign mag       = {1'b0, rom_data};

  always_comb begin
    slot_acc = '0;
    slot_en  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (slot == CH_W'(i)) begin
        slot_acc = acc[i];
        slot_en  = en[i];
      end
    end
  end

  dds_phase_decode #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_decode (
    .acc  (slot_acc),
    .addr (dec_addr),
    .sign (dec_sign)
  );

  assign rom_addr = issuing ? dec_addr : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= ISSUE;
            slot  <= '0;
          end
        end
        ISSUE: begin
          if (last_slot) state <= DRAIN;
          else           slot  <= slot + 1'b1;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A tick that lands mid-round is dropped; a new set beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    overrun <= 1'b0;
    else if (sample_tick && busy) overrun <= 1'b1;
    else if (ovr_clr)             overrun <= 1'b0;
  end

  // Config writes land at the clock edge, so an issue in the same cycle still sees the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i]    <= '0;
        tuning[i] <= '0;
      end
      en <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && cfg_ch == CH_W'(i)) begin
          tuning[i] <= cfg_tuning;
          en[i]     <= cfg_en;
        end
        if (cfg_we && cfg_ch == CH_W'(i) && cfg_clr)
          acc[i] <= '0;
        else if (issuing && slot == CH_W'(i) && en[i])
          acc[i] <= acc[i] + tuning[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid    <= 1'b0;
      p_sign     <= 1'b0;
      p_en       <= 1'b0;
      p_ch       <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
    end else begin
      p_valid   <= issuing;
      p_sign    <= dec_sign;
      p_en      <= slot_en;
      p_ch      <= slot;
      out_valid <= p_valid;
      out_ch    <= p_ch;
      if (!p_valid || !p_en) out_sample <= '0;
      else if (p_sign)       out_sample <= -mag;
      else                   out_sample <= mag;
    end
  end

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// tb/tb_dds_channel_scheduler.sv - scoreboard bench for the DDS channel scheduler
module tb_dds_channel_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_tuning;
  logic        cfg_en;
  logic        cfg_clr;
  logic        ovr_clr;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic        out_valid;
  logic [0:0]  out_ch;
  logic [8:0]  out_sample;
  logic        busy;
  logic        overrun;

  logic        tick3;
  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [5:0]  rom_addr3;
  logic [7:0]  rom_data3 = 8'd0;
  logic        out_valid3;
  logic [1:0]  out_ch3;
  logic [8:0]  out_sample3;
  logic        busy3;
  logic        overrun3;

  always #5 clk = ~clk;

  dds_channel_scheduler #(.NCH(2), .ACC_W(16), .ADDR_W(6), .DATA_W(8)) u_dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_tuning(cfg_tuning), .cfg_en(cfg_en), .cfg_clr(cfg_clr), .ovr_clr(ovr_clr),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .out_ch(out_ch),
    .out_sample(out_sample), .busy(busy), .overrun(overrun)
  );

  dds_channel_scheduler #(.NCH(3), .ACC_W(16), .ADDR_W(6), .DATA_W(8)) u_dut3 (
    .clk(clk), .reset(reset), .sample_tick(tick3), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
    .cfg_tuning(cfg_tuning), .cfg_en(cfg_en), .cfg_clr(cfg_clr), .ovr_clr(ovr_clr),
    .rom_addr(rom_addr3), .rom_data(rom_data3), .out_valid(out_valid3), .out_ch(out_ch3),
    .out_sample(out_sample3), .busy(busy3), .overrun(overrun3)
  );

  always @(posedge clk) begin
    rom_data  <= 8'(rom_addr) + 8'd10;
    rom_data3 <= 8'(rom_addr3) + 8'd10;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int         ch;
    logic [8:0] smp;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp3_q[$];

  logic [15:0] m_acc [2];
  logic [15:0] m_tun [2];
  logic        m_en  [2];

  function automatic logic [5:0] m_addr(input logic [15:0] a);
    logic [5:0] idx;
    idx = a[13:8];
    return a[14] ? ~idx : idx;
  endfunction

  function automatic logic [8:0] m_sample(input logic [15:0] a, input logic e);
    logic [8:0] mag;
    if (!e) return 9'd0;
    mag = 9'(m_addr(a)) + 9'd10;
    return a[15] ? (9'd0 - mag) : mag;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("out_ch", 32'(out_ch), 32'(e.ch));
        check("out_sample", 32'(out_sample), 32'(e.smp));
      end
    end
    if (!reset && out_valid3) begin
      if (exp3_q.size() == 0) check("unexpected_out_valid3", 32'd1, 32'd0);
      else begin
        e = exp3_q.pop_front();
        check("out_ch3", 32'(out_ch3), 32'(e.ch));
        check("out_sample3", 32'(out_sample3), 32'(e.smp));
      end
    end
  end

  task automatic cfg(input int ch, input logic [15:0] tw, input logic e, input logic clr);
    cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_tuning = tw; cfg_en = e; cfg_clr = clr;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_clr = 1'b0;
    m_tun[ch] = tw; m_en[ch] = e;
    if (clr) m_acc[ch] = 16'd0;
  endtask

  // cfg_slot / tick_slot < 0 disable the mid-round write / mid-round tick.
  task automatic round(input int cfg_slot, input logic [15:0] tw, input logic clr,
                       input int tick_slot, input logic ovr_with_tick);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("busy_issue", 32'(busy), 32'd1);
      check("rom_addr_issue", 32'(rom_addr), 32'(m_addr(m_acc[k])));
      exp_q.push_back('{ch: k, smp: m_sample(m_acc[k], m_en[k])});
      if (k == cfg_slot) begin
        cfg_we = 1'b1; cfg_ch = 1'(k); cfg_tuning = tw; cfg_en = 1'b1; cfg_clr = clr;
      end
      if (k == tick_slot) begin
        sample_tick = 1'b1; ovr_clr = ovr_with_tick;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_clr = 1'b0; sample_tick = 1'b0; ovr_clr = 1'b0;
      if (k == cfg_slot && clr) m_acc[k] = 16'd0;
      else if (m_en[k])         m_acc[k] = m_acc[k] + m_tun[k];
      if (k == cfg_slot) begin m_tun[k] = tw; m_en[k] = 1'b1; end
    end
    check("busy_drain", 32'(busy), 32'd1);
    check("rom_addr_drain", 32'(rom_addr), 32'd0);
    check("out_valid_drain", 32'(out_valid), 32'd1);
    if (tick_slot >= 0) check("overrun_set", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    check("busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("round_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_tuning = '0;
    cfg_en = 1'b0; cfg_clr = 1'b0; ovr_clr = 1'b0; tick3 = 1'b0; cfg_we3 = 1'b0; cfg_ch3 = '0;
    for (int i = 0; i < 2; i++) begin m_acc[i] = '0; m_tun[i] = '0; m_en[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_out_sample", 32'(out_sample), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // basic round: ch0 enabled, ch1 disabled
    cfg(0, 16'h0400, 1'b1, 1'b0);
    cfg(1, 16'h0000, 1'b0, 1'b0);
    round(-1, 16'h0, 1'b0, -1, 1'b0);

    // quarter mirror, sign and wrap: +10, +73, -10, -73, +10
    cfg(0, 16'h4000, 1'b1, 1'b1);
    for (int r = 0; r < 5; r++) round(-1, 16'h0, 1'b0, -1, 1'b0);
    check("wrap_acc_model", 32'(m_acc[0]), 32'h4000);

    // tick while busy: dropped, sticky overrun, then cleared
    cfg(0, 16'h0400, 1'b1, 1'b1);
    round(-1, 16'h0, 1'b0, 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("overrun_held", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);
    round(-1, 16'h0, 1'b0, 0, 1'b1);
    check("overrun_set_wins", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;

    // acc0 now 0x0800 with tuning 0x0400: mid-issue write uses old tuning
    check("acc0_before_write", 32'(m_acc[0]), 32'h0800);
    round(0, 16'h0100, 1'b0, -1, 1'b0);
    round(-1, 16'h0, 1'b0, -1, 1'b0);
    round(-1, 16'h0, 1'b0, -1, 1'b0);
    round(0, 16'h0400, 1'b1, -1, 1'b0);
    round(-1, 16'h0, 1'b0, -1, 1'b0);

    // reset while draining with out_valid high
    cfg(0, 16'h2300, 1'b1, 1'b0);
    round(-1, 16'h0, 1'b0, -1, 1'b0);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    check("pre_reset_overrun", 32'(overrun), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_out_valid", 32'(out_valid), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin m_acc[i] = '0; m_tun[i] = '0; m_en[i] = 1'b0; end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    cfg(0, 16'h1000, 1'b1, 1'b0);
    round(-1, 16'h0, 1'b0, -1, 1'b0);

    // out-of-range channel write on a 3-channel instance is ignored
    cfg_we3 = 1'b1; cfg_ch3 = 2'd2; cfg_tuning = 16'h4000; cfg_en = 1'b1; cfg_clr = 1'b0;
    @(posedge clk); #1;
    cfg_ch3 = 2'd3; cfg_tuning = 16'h1000; cfg_en = 1'b0; cfg_clr = 1'b1;
    @(posedge clk); #1;
    cfg_we3 = 1'b0; cfg_clr = 1'b0;
    for (int r = 0; r < 2; r++) begin
      exp3_q.push_back('{ch: 0, smp: 9'd0});
      exp3_q.push_back('{ch: 1, smp: 9'd0});
      exp3_q.push_back('{ch: 2, smp: (r == 0) ? 9'd10 : 9'd73});
      tick3 = 1'b1;
      @(posedge clk); #1;
      tick3 = 1'b0;
      check("busy3", 32'(busy3), 32'd1);
      repeat (7) @(posedge clk);
      #1;
    end
    check("dut3_drained", 32'(exp3_q.size()), 32'd0);
    check("dut3_overrun", 32'(overrun3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
